lc3b_control: RTL

//  Multicycle control FSM that sequences the LC-3b datapath: fetch, decode, execute and write-back
//  for the full ISA. It drives all load enables, mux selects and the ALU op, and runs the memory

---
 rtl/lc3b_control.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/lc3b_control.sv
// Multicycle LC-3b control FSM: fetch/decode/execute sequencing, datapath load enables,
// mux selects, ALU op and the cache read/write handshake.
module lc3b_control #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       branch_enable,
  input  logic       imm_check,
  input  logic       jsr_check,
  input  logic       shf_a,
  input  logic       shf_d,
  input  logic       mar_lsb,
  input  logic       mem_resp,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_cc,
  output logic       load_regfile,
  output logic [2:0] pcmux_sel,
  output logic [2:0] marmux_sel,
  output logic [2:0] regfilemux_sel,
  output logic [2:0] alumux_sel,
  output logic       mdrmux_sel,
  output logic       storemux_sel,
  output logic       r7_sel,
  output logic [3:0] aluop,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] mem_byte_enable
);

  localparam logic [3:0] OP_BR  = 4'd0,  OP_ADD = 4'd1,  OP_LDB = 4'd2,  OP_STB = 4'd3;
  localparam logic [3:0] OP_JSR = 4'd4,  OP_AND = 4'd5,  OP_LDR = 4'd6,  OP_STR = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd9,  OP_LDI = 4'd10, OP_STI = 4'd11, OP_JMP = 4'd12;
  localparam logic [3:0] OP_SHF = 4'd13, OP_LEA = 4'd14, OP_TRAP = 4'd15;

  typedef enum logic [4:0] {
    FETCH1, FETCH2, FETCH3, DECODE,
    ALU, BR, JMP, JSR1, JSR2, LEA,
    ADDR, RD1, IND, RD2, LD_WB, ST_DATA, WR,
    T1, T2, T3, HALT
  } state_t;

  state_t state;

  logic is_byte, is_ind;
  assign is_byte = (opcode == OP_LDB) || (opcode == OP_STB);
  assign is_ind  = (opcode == OP_LDI) || (opcode == OP_STI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH1;
    end else begin
      case (state)
        FETCH1:  state <= FETCH2;
        FETCH2:  if (mem_resp) state <= FETCH3;
        FETCH3:  state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_ADD, OP_AND, OP_NOT, OP_SHF: state <= ALU;
            OP_BR:   state <= BR;
            OP_JMP:  state <= JMP;
            OP_JSR:  state <= JSR1;
            OP_LEA:  state <= LEA;
            OP_LDR, OP_LDB, OP_LDI, OP_STR, OP_STB, OP_STI: state <= ADDR;
            OP_TRAP: state <= T1;
            default: state <= ILLEGAL_HALT ? HALT : FETCH1;
          endcase
        end
        JSR1:    state <= JSR2;
        ADDR:    state <= ((opcode == OP_STR) || (opcode == OP_STB)) ? ST_DATA : RD1;
        RD1:     if (mem_resp) state <= is_ind ? IND : LD_WB;
        IND:     state <= (opcode == OP_STI) ? ST_DATA : RD2;
        RD2:     if (mem_resp) state <= LD_WB;
        ST_DATA: state <= WR;
        WR:      if (mem_resp) state <= FETCH1;
        T1:      state <= T2;
        T2:      if (mem_resp) state <= T3;
        HALT:    state <= HALT;
        default: state <= FETCH1;
      endcase
    end
  end

  // Outputs decode the current state; IR fields are stable from DECODE onward.
  // Gating with reset makes an in-flight request drop in the same cycle reset rises.
  always_comb begin
    load_pc         = 1'b0;
    load_ir         = 1'b0;
    load_mar        = 1'b0;
    load_mdr        = 1'b0;
    load_cc         = 1'b0;
    load_regfile    = 1'b0;
    pcmux_sel       = 3'd0;
    marmux_sel      = 3'd0;
    regfilemux_sel  = 3'd0;
    alumux_sel      = 3'd0;
    mdrmux_sel      = 1'b0;
    storemux_sel    = 1'b0;
    r7_sel          = 1'b0;
    aluop           = 4'd0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 2'b11;
    if (!reset) begin
      case (state)
        FETCH1: begin
          marmux_sel = 3'd1;
          load_mar   = 1'b1;
        end
        FETCH2, RD1, RD2, T2: begin
          mem_read   = 1'b1;
          mdrmux_sel = 1'b1;
          load_mdr   = 1'b1;
        end
        FETCH3: load_ir = 1'b1;
        DECODE: load_pc = 1'b1;
        ALU: begin
          load_regfile = 1'b1;
          load_cc      = 1'b1;
          case (opcode)
            OP_ADD: alumux_sel = imm_check ? 3'd2 : 3'd0;
            OP_AND: begin
              alumux_sel = imm_check ? 3'd2 : 3'd0;
              aluop      = 4'd1;
            end
            OP_NOT: aluop = 4'd2;
            OP_SHF: begin
              alumux_sel = 3'd3;
              aluop      = !shf_d ? 4'd4 : (shf_a ? 4'd6 : 4'd5);
            end
            default: ;
          endcase
        end
        BR: begin
          pcmux_sel = 3'd1;
          load_pc   = branch_enable;
        end
        JMP: begin
          pcmux_sel = 3'd2;
          load_pc   = 1'b1;
        end
        JSR1: begin
          r7_sel         = 1'b1;
          regfilemux_sel = 3'd3;
          load_regfile   = 1'b1;
        end
        JSR2: begin
          pcmux_sel = jsr_check ? 3'd4 : 3'd2;
          load_pc   = 1'b1;
        end
        LEA: begin
          regfilemux_sel = 3'd2;
          load_regfile   = 1'b1;
          load_cc        = 1'b1;
        end
        ADDR: begin
          alumux_sel = 3'd1;
          marmux_sel = is_byte ? 3'd4 : 3'd0;
          load_mar   = 1'b1;
        end
        IND: begin
          marmux_sel = 3'd2;
          load_mar   = 1'b1;
        end
        LD_WB: begin
          regfilemux_sel = is_byte ? 3'd4 : 3'd1;
          load_regfile   = 1'b1;
          load_cc        = 1'b1;
        end
        ST_DATA: begin
          storemux_sel = 1'b1;
          aluop        = 4'd3;
          load_mdr     = 1'b1;
        end
        WR: begin
          mem_write = 1'b1;
          if (opcode == OP_STB) mem_byte_enable = mar_lsb ? 2'b10 : 2'b01;
        end
        T1: begin
          marmux_sel     = 3'd3;
          load_mar       = 1'b1;
          r7_sel         = 1'b1;
          regfilemux_sel = 3'd3;
          load_regfile   = 1'b1;
        end
        T3: begin
          pcmux_sel = 3'd3;
          load_pc   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
